mux_arb_nx1: RTL and testbench
==============================

MUX_ARB_NX1 -- requirements
Module: mux_arb_nx1

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input channel and of the output.
REQ-002 Parameter N, default 4, legal range 2..16: number of input channels.
REQ-003 Localparam SELW = clog2(N): width of channel indices.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 inp  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 inp_valid  input  N  per-channel data valid.
REQ-009 inp_ready  output  N  per-channel accept; combinational.
REQ-010 sel  input  SELW  channel index used in fixed mode.
REQ-011 mode  input  1  0 = fixed select on sel, 1 = round-robin.
REQ-012 out  output  WIDTH  registered selected data.
REQ-013 out_valid  output  1  out register holds data.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 out_src  output  SELW  index of the channel that supplied out.

Function
REQ-016 The block SHALL hold one output entry; can_accept = !out_valid | out_ready.
REQ-017 Fixed mode: the candidate SHALL be channel sel; a grant occurs iff inp_valid[sel] & can_accept.
REQ-018 Fixed mode with sel >= N: no grant; all inp_ready SHALL be 0.
REQ-019 Round-robin mode: the candidate SHALL be the first i with inp_valid[i] set, searching from ptr upward and wrapping N-1 -> 0.
REQ-020 Round-robin mode with no inp_valid bit set: no grant.
REQ-021 inp_ready[i] SHALL be 1 only for the candidate channel, and only when can_accept; all other bits SHALL be 0.
REQ-022 inp_ready SHALL NOT depend on inp_valid of the channel it drives in fixed mode; in round-robin mode it SHALL depend on inp_valid.
REQ-023 On a grant, out <= candidate data, out_src <= candidate index and out_valid <= 1 at the next rising edge (latency 1 cycle).
REQ-024 On out_valid & out_ready with no grant, out_valid <= 0; out and out_src SHALL hold their values.
REQ-025 Simultaneous drain and grant in one cycle SHALL load the new entry with out_valid staying 1 (full throughput: one word per cycle).
REQ-026 While out_valid & !out_ready, out and out_src SHALL be stable.
REQ-027 ptr (SELW bits) SHALL update only on a round-robin grant, to (granted index + 1) mod N; the update wraps N-1 -> 0 for every N, including N that is not a power of two.
REQ-028 ptr SHALL hold its value in fixed mode; a mode change takes effect for the candidate in the same cycle.

Reset
REQ-029 While rst_n is 0: out = 0, out_src = 0, out_valid = 0, ptr = 0; inp_ready SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL discard the held entry; no partial state SHALL survive.
REQ-031 After rst_n deasserts, the first grant SHALL be possible on the first rising edge.

Configuration
REQ-032 Macro MUX_ARB_STALL_CNT_EN: when defined, an output port stall_cnt (16 bits) SHALL be present.
REQ-033 stall_cnt SHALL reset to 0 and SHALL increment on every cycle with out_valid & !out_ready.
REQ-034 stall_cnt SHALL saturate at 16'hFFFF.
REQ-035 When MUX_ARB_STALL_CNT_EN is undefined, the port and the counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-036 Fixed mode, N=4, sel=2, inp_valid=4'b0100, channel 2 data 32'h3b3b3b3b, out_ready=1 -> inp_ready=4'b0100; the next cycle gives out=32'h3b3b3b3b, out_src=2, out_valid=1.
REQ-037 Round-robin, all four channels valid every cycle, out_ready=1, starting after reset -> out_src sequence is 0,1,2,3,0; one word per cycle.
REQ-038 Backpressure: out_valid=1 with out_ready=0 for 3 cycles -> out is stable, inp_ready=0, and stall_cnt=3 (macro defined).
REQ-039 N=3, round-robin, only channel 2 valid, then all channels valid -> after granting 2, ptr wraps to 0 and the next grant is channel 0.
REQ-040 rst_n pulsed low asynchronously while out_valid=1 -> out_valid, out and out_src read 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mux_arb_nx1.sv
// mux_arb_nx1: N-to-1 channel multiplexer with a single registered output
// entry. It supports fixed selection on sel, or round-robin arbitration
// from a rotating pointer. One word per cycle is possible when downstream
// accepts.
// Optional feature: define MUX_ARB_STALL_CNT_EN to add a saturating 16-bit
// stall_cnt output that counts cycles where out_valid is high and
// out_ready is low.
module mux_arb_nx1 #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] inp,
  input  logic [N-1:0]       inp_valid,
  output logic [N-1:0]       inp_ready,
  input  logic [SELW-1:0]    sel,
  input  logic               mode,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_src
`ifdef MUX_ARB_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  // Pad the channel vectors to a power of two. An out-of-range sel can then
  // index them safely; the padded lanes are never granted.
  localparam int PADN = 1 << SELW;
  localparam int PADW = PADN * WIDTH;

  logic [PADN-1:0]  valid_pad;
  logic [PADW-1:0]  inp_pad;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  cand;
  logic             cand_ok;
  logic             can_accept;
  logic             grant;
  logic [WIDTH-1:0] cand_data;

  assign valid_pad  = PADN'(inp_valid);
  assign inp_pad    = PADW'(inp);
  assign can_accept = !out_valid || out_ready;
  assign grant      = cand_ok && can_accept && valid_pad[cand];
  assign cand_data  = inp_pad[cand*WIDTH +: WIDTH];

  // Pick the candidate channel. Fixed mode uses sel as-is. Round-robin
  // mode takes the first valid channel at or after ptr, wrapping at N.
  always_comb begin
    int idx;
    idx     = 0;
    cand    = '0;
    cand_ok = 1'b0;
    if (!mode) begin
      cand    = sel;
      cand_ok = (int'(sel) < N);
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!cand_ok && valid_pad[idx[SELW-1:0]]) begin
          cand_ok = 1'b1;
          cand    = idx[SELW-1:0];
        end
      end
    end
  end

  // Only the candidate channel sees ready. In fixed mode, ready does not
  // depend on that channel's own valid. Ready is forced low during reset.
  always_comb begin
    inp_ready = '0;
    for (int i = 0; i < N; i++)
      inp_ready[i] = rst_n && cand_ok && can_accept && (cand == SELW'(i));
  end

  // Output entry and round-robin pointer. A grant overrides a drain in the
  // same cycle, so out_valid stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else begin
      if (grant) begin
        out       <= cand_data;
        out_src   <= cand;
        out_valid <= 1'b1;
        if (mode)
          ptr <= (cand == SELW'(N-1)) ? '0 : cand + SELW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_STALL_CNT_EN
  // Count cycles where downstream blocks the held entry. The count
  // saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Testbench for mux_arb_nx1: a 4-channel instance (main tests) and a
// 3-channel instance (pointer wrap and out-of-range sel).
module tb_mux_arb_nx1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [127:0] inp4;
  logic [3:0]   v4, rdy4;
  logic [1:0]   sel4, src4;
  logic         mode4, ordy4, ov4;
  logic [31:0]  out4;

  logic [95:0]  inp3;
  logic [2:0]   v3, rdy3;
  logic [1:0]   sel3, src3;
  logic         mode3, ordy3, ov3;
  logic [31:0]  out3;

`ifdef MUX_ARB_STALL_CNT_EN
  logic [15:0]  stall4, stall3;
`endif

  mux_arb_nx1 #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .inp(inp4), .inp_valid(v4), .inp_ready(rdy4),
    .sel(sel4), .mode(mode4), .out(out4), .out_valid(ov4), .out_ready(ordy4),
    .out_src(src4)
`ifdef MUX_ARB_STALL_CNT_EN
    , .stall_cnt(stall4)
`endif
  );

  mux_arb_nx1 #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .inp(inp3), .inp_valid(v3), .inp_ready(rdy3),
    .sel(sel3), .mode(mode3), .out(out3), .out_valid(ov3), .out_ready(ordy3),
    .out_src(src3)
`ifdef MUX_ARB_STALL_CNT_EN
    , .stall_cnt(stall3)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model state for the 4-channel instance.
  logic [31:0] m_out;
  int          m_src, m_ptr;
  bit          m_valid;
  int          m_stall;

  // Candidate computed from the arbitration rules with plain arithmetic.
  function automatic void ref_cand(input int n, input bit m, input int s,
                                   input logic [15:0] v, input int p,
                                   output bit ok, output int idx);
    ok = 0; idx = 0;
    if (!m) begin
      ok = (s < n); idx = s;
    end else begin
      for (int k = n - 1; k >= 0; k--)
        if (v[(p + k) % n]) begin ok = 1; idx = (p + k) % n; end
    end
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 4; i++) inp4[i*32 +: 32] = $urandom;
    for (int i = 0; i < 3; i++) inp3[i*32 +: 32] = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_out = 0; m_src = 0; m_ptr = 0; m_valid = 0; m_stall = 0;
  endtask

  task automatic test_reset();
    mode4 = 0; sel4 = 0; v4 = 4'hF; ordy4 = 1;
    mode3 = 0; sel3 = 0; v3 = 3'h7; ordy3 = 1;
    rand_data();
    rst_n = 1'b0;
    #2;
    total++; if (rdy4 !== 4'b0) begin bad++; $display("FAIL reset_rdy4 got=%b exp=0000", rdy4); end
    total++; if (rdy3 !== 3'b0) begin bad++; $display("FAIL reset_rdy3 got=%b exp=000", rdy3); end
    @(posedge clk); #1;
    total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL reset_ov got=%b exp=0", ov4); end
    total++; if (out4 !== 32'h0) begin bad++; $display("FAIL reset_out got=%h exp=0", out4); end
    total++; if (src4 !== 2'd0) begin bad++; $display("FAIL reset_src got=%0d exp=0", src4); end
`ifdef MUX_ARB_STALL_CNT_EN
    total++; if (stall4 !== 16'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall4); end
`endif
    rst_n = 1'b1;
    v3 = 0;
  endtask

  task automatic test_fixed();
    do_reset();
    rand_data();
    mode4 = 0; sel4 = 2; ordy4 = 1; inp4[64 +: 32] = 32'h3b3b3b3b;
    v4 = 4'b0000;
    #1;
    total++; if (rdy4 !== 4'b0100) begin bad++; $display("FAIL fixed_rdy_novalid got=%b exp=0100", rdy4); end
    v4 = 4'b0100;
    #1;
    total++; if (rdy4 !== 4'b0100) begin bad++; $display("FAIL fixed_rdy got=%b exp=0100", rdy4); end
    @(posedge clk); #1;
    total++; if (out4 !== 32'h3b3b3b3b) begin bad++; $display("FAIL fixed_out got=%h exp=3b3b3b3b", out4); end
    total++; if (src4 !== 2'd2) begin bad++; $display("FAIL fixed_src got=%0d exp=2", src4); end
    total++; if (ov4 !== 1'b1) begin bad++; $display("FAIL fixed_ov got=%b exp=1", ov4); end
  endtask

  task automatic test_rr_seq();
    logic [31:0] d;
    do_reset();
    mode4 = 1; v4 = 4'hF; ordy4 = 1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      d = inp4[(k % 4)*32 +: 32];
      #1;
      total++; if (rdy4 !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_rdy k=%0d got=%b exp=%b", k, rdy4, 4'(1 << (k % 4))); end
      @(posedge clk); #1;
      total++; if (src4 !== 2'(k % 4) || ov4 !== 1'b1 || out4 !== d)
        begin bad++; $display("FAIL rr_seq k=%0d got src=%0d ov=%b out=%h exp src=%0d ov=1 out=%h", k, src4, ov4, out4, k % 4, d); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    do_reset();
    rand_data();
    mode4 = 0; sel4 = 1; v4 = 4'b0010; ordy4 = 1;
    d = inp4[32 +: 32];
    @(posedge clk); #1;
    ordy4 = 0; v4 = 4'hF;
    for (int k = 0; k < 3; k++) begin
      rand_data();
      #1;
      total++; if (rdy4 !== 4'b0) begin bad++; $display("FAIL bp_rdy k=%0d got=%b exp=0000", k, rdy4); end
      @(posedge clk); #1;
      total++; if (out4 !== d || ov4 !== 1'b1 || src4 !== 2'd1)
        begin bad++; $display("FAIL bp_hold k=%0d got out=%h ov=%b src=%0d exp out=%h ov=1 src=1", k, out4, ov4, src4, d); end
    end
`ifdef MUX_ARB_STALL_CNT_EN
    total++; if (stall4 !== 16'd3) begin bad++; $display("FAIL bp_stall got=%0d exp=3", stall4); end
`endif
    ordy4 = 1; v4 = 4'b0;
    @(posedge clk); #1;
    total++; if (ov4 !== 1'b0 || out4 !== d || src4 !== 2'd1)
      begin bad++; $display("FAIL bp_drain got ov=%b out=%h src=%0d exp ov=0 out=%h src=1", ov4, out4, src4, d); end
  endtask

  task automatic test_n3_wrap();
    do_reset();
    rand_data();
    mode3 = 1; v3 = 3'b100; ordy3 = 1;
    #1;
    total++; if (rdy3 !== 3'b100) begin bad++; $display("FAIL n3_rdy_first got=%b exp=100", rdy3); end
    @(posedge clk); #1;
    total++; if (src3 !== 2'd2 || out3 !== inp3[64 +: 32]) begin bad++; $display("FAIL n3_first got src=%0d out=%h exp src=2", src3, out3); end
    v3 = 3'b111;
    #1;
    total++; if (rdy3 !== 3'b001) begin bad++; $display("FAIL n3_rdy_wrap got=%b exp=001", rdy3); end
    @(posedge clk); #1;
    total++; if (src3 !== 2'd0) begin bad++; $display("FAIL n3_wrap got src=%0d exp=0", src3); end
    mode3 = 0; sel3 = 3;
    #1;
    total++; if (rdy3 !== 3'b000) begin bad++; $display("FAIL n3_sel_oor_rdy got=%b exp=000", rdy3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL n3_sel_oor_ov got=%b exp=0", ov3); end
    v3 = 0; mode3 = 0; sel3 = 0;
  endtask

  task automatic test_async_reset();
    do_reset();
    rand_data();
    mode4 = 0; sel4 = 3; v4 = 4'b1000; ordy4 = 1;
    inp4[96 +: 32] = inp4[96 +: 32] | 32'h1;
    @(posedge clk); #1;
    ordy4 = 0;
    total++; if (ov4 !== 1'b1 || src4 !== 2'd3) begin bad++; $display("FAIL ar_load got ov=%b src=%0d exp ov=1 src=3", ov4, src4); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ov4 !== 1'b0 || out4 !== 32'h0 || src4 !== 2'd0)
      begin bad++; $display("FAIL ar_clear got ov=%b out=%h src=%0d exp 0 0 0", ov4, out4, src4); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_out = 0; m_src = 0; m_ptr = 0; m_valid = 0; m_stall = 0;
  endtask

  task automatic test_random();
    bit ok, gnt, ca;
    int idx;
    logic [3:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rand_data();
      mode4 = 1'($urandom_range(0, 1));
      sel4  = 2'($urandom);
      v4    = 4'($urandom);
      ordy4 = ($urandom_range(0, 3) != 0);
      #1;
      ref_cand(4, mode4, int'(sel4), 16'(v4), m_ptr, ok, idx);
      ca = !m_valid || ordy4;
      exp_rdy = (ok && ca) ? 4'(1 << idx) : 4'b0;
      gnt = ok && ca && v4[idx];
      total++; if (rdy4 !== exp_rdy) begin bad++; $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, rdy4, exp_rdy); end
      @(posedge clk); #1;
      if (m_valid && !ordy4 && m_stall < 16'hFFFF) m_stall++;
      if (gnt) begin
        m_out = inp4[idx*32 +: 32]; m_src = idx; m_valid = 1;
        if (mode4) m_ptr = (idx + 1) % 4;
      end else if (m_valid && ordy4) begin
        m_valid = 0;
      end
      total++; if (out4 !== m_out || src4 !== 2'(m_src) || ov4 !== m_valid)
        begin bad++; $display("FAIL rand_out c=%0d got out=%h src=%0d ov=%b exp out=%h src=%0d ov=%b", c, out4, src4, ov4, m_out, m_src, m_valid); end
`ifdef MUX_ARB_STALL_CNT_EN
      total++; if (stall4 !== 16'(m_stall)) begin bad++; $display("FAIL rand_stall c=%0d got=%0d exp=%0d", c, stall4, m_stall); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_seq();
    test_backpressure();
    test_n3_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
